fir_deconv: RTL and testbench

//  Inverse (decoder) of the 5-tap unit-coefficient FIR moving-sum filter: recovers the

---
 rtl/fir_deconv.sv | 172 +++++++++++++++++
 tb/tb_fir_deconv.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_deconv.sv
// -----------------------------------------------------------------------------
// fir_deconv
//   Inverse of the 5-tap unit-coefficient moving-sum FIR. Recovers the signed
//   sample stream x[n] from the filtered stream y[n] = x[n] + ... + x[n-4]:
//       x[n] = y[n] - (x[n-1] + x[n-2] + x[n-3] + x[n-4])
//   The sum of the last four recovered samples is kept as a registered
//   running sum, so each sample needs one subtract plus one sum update.
//   The history starts at zero after reset/clear, matching the zeroed delay
//   chain of a freshly reset filter.
//
// Build option:
//   FIR_DECONV_SAT_EN  defined   : out-of-range differences saturate to the
//                                  x range and set the sticky err flag.
//                      undefined : differences wrap (two's complement) into
//                                  NUM_INPUT_BITS; err is tied to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   clear      in   synchronous history/counter clear (err is kept)
//   in_y       in   signed filtered sample  [NUM_OUTPUT_BITS]
//   in_valid   in   in_y valid
//   in_ready   out  block can accept in_y this cycle (combinational)
//   out_x      out  signed recovered sample [NUM_INPUT_BITS], registered
//   out_valid  out  out_x valid, registered
//   out_ready  in   consumer accepts out_x this cycle
//   count      out  samples accepted since reset/clear, wraps [CNT_BITS]
//   err        out  sticky range error (saturating build only)
// -----------------------------------------------------------------------------
module fir_deconv #(
    parameter int NUM_INPUT_BITS  = 4,
    parameter int NUM_OUTPUT_BITS = 16,
    parameter int CNT_BITS        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [NUM_OUTPUT_BITS-1:0] in_y,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NUM_INPUT_BITS-1:0]  out_x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_BITS-1:0]        count,
    output logic                       err
);

    // Difference width: one guard bit over y so y - S never overflows.
    localparam int DW = NUM_OUTPUT_BITS + 1;
    // Running-sum width: four NUM_INPUT_BITS values need two extra bits;
    // one more keeps the intermediate S + x - h4 comfortably in range.
    localparam int SW = NUM_INPUT_BITS + 3;
    localparam int XW = NUM_INPUT_BITS;

    logic [XW-1:0]        h1_r;
    logic [XW-1:0]        h2_r;
    logic [XW-1:0]        h3_r;
    logic [XW-1:0]        h4_r;
    logic [SW-1:0]        sum_r;
    logic [SW-1:0]        sum_next_s;
    logic [XW-1:0]        out_x_r;
    logic                 out_valid_r;
    logic [CNT_BITS-1:0]  count_r;
    logic [XW-1:0]        x_new_s;
    logic signed [DW-1:0] d_s;
    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 out_fire_s;

    // Handshake: single output register, so a new sample may enter whenever
    // the register is empty or being drained this cycle; clear blocks input.
    always_comb begin
        in_ready_s = ~clear & (~out_valid_r | out_ready);
        in_fire_s  = in_valid & in_ready_s;
        out_fire_s = out_valid_r & out_ready;
    end

    // Raw difference y - S in DW signed bits (both operands sign-extended).
    always_comb begin
        d_s = $signed({in_y[NUM_OUTPUT_BITS-1], in_y})
            - $signed({{(DW-SW){sum_r[SW-1]}}, sum_r});
    end

`ifdef FIR_DECONV_SAT_EN
    localparam logic signed [DW-1:0] X_MAX = {{(DW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [DW-1:0] X_MIN = {{(DW-XW+1){1'b1}}, {(XW-1){1'b0}}};

    logic range_err_s;
    logic err_r;

    // Narrow the difference to the x range, clamping to the nearest bound.
    always_comb begin
        x_new_s     = d_s[XW-1:0];
        range_err_s = 1'b0;
        if (d_s > X_MAX) begin
            x_new_s     = X_MAX[XW-1:0];
            range_err_s = 1'b1;
        end else if (d_s < X_MIN) begin
            x_new_s     = X_MIN[XW-1:0];
            range_err_s = 1'b1;
        end else begin
            x_new_s     = d_s[XW-1:0];
            range_err_s = 1'b0;
        end
    end

    // Sticky range error: only reset clears it, clear leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (in_fire_s && range_err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic unused_d_hi_s;

    // Narrow the difference by two's-complement wrap (keep the low bits).
    always_comb begin
        x_new_s = d_s[XW-1:0];
    end

    // The wrapped build intentionally discards the upper difference bits.
    assign unused_d_hi_s = ^d_s[DW-1:XW];
    assign err           = 1'b0;
`endif

    // Next running sum: add the sample entering the window, drop the oldest.
    always_comb begin
        sum_next_s = sum_r
                   + {{(SW-XW){x_new_s[XW-1]}}, x_new_s}
                   - {{(SW-XW){h4_r[XW-1]}}, h4_r};
    end

    // History, running sum, output register and sample counter.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            h1_r        <= {XW{1'b0}};
            h2_r        <= {XW{1'b0}};
            h3_r        <= {XW{1'b0}};
            h4_r        <= {XW{1'b0}};
            sum_r       <= {SW{1'b0}};
            out_x_r     <= {XW{1'b0}};
            out_valid_r <= 1'b0;
            count_r     <= {CNT_BITS{1'b0}};
        end else if (in_fire_s) begin
            // History advances only on accepted samples.
            h4_r        <= h3_r;
            h3_r        <= h2_r;
            h2_r        <= h1_r;
            h1_r        <= x_new_s;
            sum_r       <= sum_next_s;
            out_x_r     <= x_new_s;
            out_valid_r <= 1'b1;
            count_r     <= count_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_x     = out_x_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;

endmodule

// File: tb/tb_fir_deconv.sv
module tb_fir_deconv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in_y = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  out_x;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] count;
    logic        err;

    fir_deconv dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_y      (in_y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_x     (out_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: last four recovered samples, newest first.
    int hist[4];
    int m_cnt = 0;
    int m_err = 0;
    int expq[$];
    bit rand_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // x = y - (sum of previous four x), narrowed to a signed 4-bit value.
    function automatic int ref_step(input int y);
        int d;
        int x;
        d = y - (hist[0] + hist[1] + hist[2] + hist[3]);
`ifdef FIR_DECONV_SAT_EN
        if (d > 7) begin
            x = 7; m_err = 1;
        end else if (d < -8) begin
            x = -8; m_err = 1;
        end else begin
            x = d;
        end
`else
        x = d & 15;
        if (x > 7) x = x - 16;
`endif
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = x;
        m_cnt = (m_cnt + 1) % 65536;
        return x;
    endfunction

    task automatic model_flush(input bit full);
        for (int i = 0; i < 4; i++) hist[i] = 0;
        m_cnt = 0;
        expq.delete();
        if (full) m_err = 0;
    endtask

    // Monitor: every accepted output is popped and compared.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                chk("out_x", int'($signed(out_x)), expq.pop_front());
            end
        end
    end

    // Offer one y; fires when in_ready is seen. Leaves in_valid high.
    task automatic send(input int y, input bit use_exp, input int exp_x);
        int waited;
        int x;
        waited = 0;
        in_y = y[15:0];
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 50) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rand_en) out_ready = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk);
        x = ref_step(y);
        expq.push_back(use_exp ? exp_x : x);
        #1;
        chk("latency_valid", int'(out_valid), 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_flush(1'b1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_err", int'(err), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        in_valid = 1'b1;
        in_y = 16'(($urandom_range(0, 20)));
        @(negedge clk);
        chk("clear_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        model_flush(1'b0);
        chk("clear_out_valid", int'(out_valid), 0);
        chk("clear_count", int'(count), 0);
        chk("clear_err", int'(err), m_err);
    endtask

    initial begin
        int g[4];
        int x;
        int y;
        int waited;
        for (int i = 0; i < 4; i++) hist[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        chk("rst_in_ready", int'(in_ready), 1);

        // 1: back-to-back known sequence -> 1,2,3,-4,7
        send(1, 1'b1, 1);
        send(3, 1'b1, 2);
        send(6, 1'b1, 3);
        send(2, 1'b1, -4);
        send(9, 1'b1, 7);
        idle(2);
        chk("t1_count", int'(count), 5);

        // 3: backpressure
        do_clear();
        send(1, 1'b0, 0);
        out_ready = 1'b0;
        in_y = 16'd3;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_x_held", int'($signed(out_x)), 1);
            chk("bp_count", int'(count), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3, 1'b1, 2);
        idle(2);
        chk("bp_count_after", int'(count), 2);

        // 4: overflow on first sample
        do_clear();
        send(100, 1'b0, 0);
        send(100, 1'b0, 0);
        idle(2);
        chk("ovf_err", int'(err), m_err);

        // 5: clear mid-history, then y=5 -> 5
        send(1, 1'b0, 0);
        send(3, 1'b0, 0);
        idle(2);
        do_clear();
        send(5, 1'b1, 5);
        idle(2);
        chk("clr_count", int'(count), 1);
        chk("clr_err_kept", int'(err), m_err);

        // 6: reset while output stalled
        send(4, 1'b0, 0);
        out_ready = 1'b0;
        idle(1);
        chk("stall_valid", int'(out_valid), 1);
        do_reset();
        out_ready = 1'b1;
        send(2, 1'b1, 2);
        idle(2);

        // 2: loopback through a behavioural moving-sum filter, random flow
        do_clear();
        for (int i = 0; i < 4; i++) g[i] = 0;
        rand_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            x = int'($urandom_range(0, 15)) - 8;
            y = x + g[0] + g[1] + g[2] + g[3];
            g[3] = g[2]; g[2] = g[1]; g[1] = g[0]; g[0] = x;
            if ($urandom_range(0, 3) == 0) idle(1);
            out_ready = ($urandom_range(0, 2) != 0);
            send(y, 1'b1, x);
        end
        rand_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (expq.size() != 0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("drain", expq.size(), 0);
        chk("loop_count", int'(count), m_cnt);
        chk("loop_err", int'(err), m_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
